// File: rtl/mem_arb2_if.sv
// mem_arb2_if: requester-side and memory-side buses of the two-port memory arbiter
interface mem_arb2_if #(
    parameter int logsize = 7
);
    logic               c0_req;
    logic               c0_we;
    logic [logsize-1:0] c0_addr;
    logic [7:0]         c0_wdata;
    logic               c0_ack;
    logic [7:0]         c0_rdata;
    logic               c1_req;
    logic               c1_we;
    logic [logsize-1:0] c1_addr;
    logic [7:0]         c1_wdata;
    logic               c1_ack;
    logic [7:0]         c1_rdata;
    logic [logsize-1:0] mem_addr;
    logic [7:0]         mem_wdata;
    logic               mem_wselect;
    logic               mem_doit;
    logic               mem_busy;
    logic               mem_rvalid;
    logic [7:0]         mem_rdata;
    logic               grant;
    logic               err;

    modport slave (
        input  c0_req, c0_we, c0_addr, c0_wdata,
        input  c1_req, c1_we, c1_addr, c1_wdata,
        input  mem_busy, mem_rvalid, mem_rdata,
        output c0_ack, c0_rdata, c1_ack, c1_rdata,
        output mem_addr, mem_wdata, mem_wselect, mem_doit,
        output grant, err
    );

    modport master (
        output c0_req, c0_we, c0_addr, c0_wdata,
        output c1_req, c1_we, c1_addr, c1_wdata,
        output mem_busy, mem_rvalid, mem_rdata,
        input  c0_ack, c0_rdata, c1_ack, c1_rdata,
        input  mem_addr, mem_wdata, mem_wselect, mem_doit,
        input  grant, err
    );
endinterface

// File: rtl/mem_arb2.sv
// mem_arb2: two-port arbiter/sequencer for a single-port byte memory; MEM_ARB_RR_EN selects round-robin ties
module mem_arb2 #(
    parameter int logsize = 7,
    parameter int TIMEOUT = 15
) (
    input logic       clk,
    input logic       rst,
    mem_arb2_if.slave bus
);
    localparam int CW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      cnt;
    logic               win;
    logic               doit;
    logic               any_req;
    logic               timeout;
    logic               capture;
    logic [7:0]         rd_val;
    logic [logsize-1:0] addr;
    logic [7:0]         wdata;
    logic               wsel;
    logic               grant;
    logic               err;
    logic [7:0]         rdata0;
    logic [7:0]         rdata1;

    assign any_req = bus.c0_req || bus.c1_req;
    assign timeout = cnt == CW'(TIMEOUT - 1);
    assign capture = state == WAIT && (bus.mem_rvalid || timeout);
    assign rd_val  = bus.mem_rvalid ? bus.mem_rdata : 8'hFF;

`ifdef MEM_ARB_RR_EN
    logic last;

    // Remember which port was served last so a tie goes to the other one
    always_ff @(posedge clk or negedge rst)
        if (!rst) last <= 1'b1;
        else if (state == RESP) last <= grant;

    assign win = (bus.c0_req && bus.c1_req) ? ~last : bus.c1_req;
`else
    assign win = ~bus.c0_req;
`endif

    // State register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    // Next state and the single-cycle memory strobe
    always_comb begin
        state_nx = state;
        doit     = 1'b0;
        case (state)
            IDLE:    state_nx = any_req ? ISSUE : IDLE;
            ISSUE:   begin
                doit     = !bus.mem_busy;
                state_nx = bus.mem_busy ? ISSUE : (wsel ? RESP : WAIT);
            end
            WAIT:    state_nx = (bus.mem_rvalid || timeout) ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // Latch the winning command, capture read data, run the timeout counter
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            addr   <= '0;
            wdata  <= 8'h00;
            wsel   <= 1'b0;
            grant  <= 1'b0;
            err    <= 1'b0;
            rdata0 <= 8'h00;
            rdata1 <= 8'h00;
            cnt    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant <= win;
                addr  <= win ? bus.c1_addr : bus.c0_addr;
                wdata <= win ? bus.c1_wdata : bus.c0_wdata;
                wsel  <= win ? bus.c1_we : bus.c0_we;
            end
            if (doit) cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if (capture && grant) rdata1 <= rd_val;
            if (capture && !grant) rdata0 <= rd_val;
            if (capture && !bus.mem_rvalid) err <= 1'b1;
        end

    assign bus.c0_ack      = state == RESP && !grant;
    assign bus.c1_ack      = state == RESP && grant;
    assign bus.c0_rdata    = rdata0;
    assign bus.c1_rdata    = rdata1;
    assign bus.mem_addr    = addr;
    assign bus.mem_wdata   = wdata;
    assign bus.mem_wselect = wsel;
    assign bus.mem_doit    = doit;
    assign bus.grant       = grant;
    assign bus.err         = err;
endmodule

// File: tb/tb_mem_arb2.sv
// tb_mem_arb2: directed self-checking bench for mem_arb2 with a one-cycle memory model
module tb_mem_arb2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mute = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   doit_cnt = 0;
    logic [7:0] mem [128];

    mem_arb2_if #(.logsize(7)) b ();

    mem_arb2 #(.logsize(7), .TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(b));

    always #5 clk = ~clk;

    // One-cycle memory: read data returns the cycle after mem_doit; mute suppresses it
    always @(posedge clk or negedge rst)
        if (!rst) begin
            b.mem_rvalid <= 1'b0;
            b.mem_rdata  <= 8'h00;
            for (int i = 0; i < 128; i++) mem[i] <= 8'(8'h40 + i);
        end else begin
            b.mem_rvalid <= b.mem_doit && !b.mem_wselect && !mute;
            b.mem_rdata  <= mem[b.mem_addr];
            if (b.mem_doit && b.mem_wselect) mem[b.mem_addr] <= b.mem_wdata;
        end

    always @(posedge clk) if (b.mem_doit === 1'b1) doit_cnt <= doit_cnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_any(input int max, output int lat, output int port, output bit both);
        lat = -1;
        port = -1;
        both = 1'b0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (b.c0_ack && b.c1_ack) both = 1'b1;
            if (b.c0_ack || b.c1_ack) begin
                lat = i;
                port = b.c1_ack ? 1 : 0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        n_cmp++; if (b.mem_doit !== 1'b0) begin n_bad++; $display("FAIL rst_doit: got %b want 0", b.mem_doit); end
        n_cmp++; if ({b.c0_ack, b.c1_ack} !== 2'b00) begin n_bad++; $display("FAIL rst_acks: got %b want 00", {b.c0_ack, b.c1_ack}); end
        n_cmp++; if (b.mem_addr !== 7'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", b.mem_addr); end
        n_cmp++; if ({b.mem_wdata, b.mem_wselect} !== 9'd0) begin n_bad++; $display("FAIL rst_wdata_wsel: got %h want 0", {b.mem_wdata, b.mem_wselect}); end
        n_cmp++; if ({b.c0_rdata, b.c1_rdata} !== 16'h0000) begin n_bad++; $display("FAIL rst_rdata: got %h want 0000", {b.c0_rdata, b.c1_rdata}); end
        n_cmp++; if ({b.grant, b.err} !== 2'b00) begin n_bad++; $display("FAIL rst_grant_err: got %b want 00", {b.grant, b.err}); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write;
        int d0;
        d0 = doit_cnt;
        b.c0_we = 1'b1; b.c0_addr = 7'd5; b.c0_wdata = 8'hA5; b.c0_req = 1'b1;
        tick();
        n_cmp++; if (b.mem_doit !== 1'b1) begin n_bad++; $display("FAIL wr_doit: got %b want 1", b.mem_doit); end
        n_cmp++; if (b.mem_addr !== 7'd5) begin n_bad++; $display("FAIL wr_addr: got %h want 05", b.mem_addr); end
        n_cmp++; if (b.mem_wselect !== 1'b1) begin n_bad++; $display("FAIL wr_wsel: got %b want 1", b.mem_wselect); end
        n_cmp++; if (b.mem_wdata !== 8'hA5) begin n_bad++; $display("FAIL wr_wdata: got %h want a5", b.mem_wdata); end
        n_cmp++; if (b.c0_ack !== 1'b0) begin n_bad++; $display("FAIL wr_early_ack: got %b want 0", b.c0_ack); end
        tick();
        n_cmp++; if ({b.c0_ack, b.c1_ack} !== 2'b10) begin n_bad++; $display("FAIL wr_ack: got %b want 10", {b.c0_ack, b.c1_ack}); end
        n_cmp++; if (b.mem_doit !== 1'b0) begin n_bad++; $display("FAIL wr_doit_once: got %b want 0", b.mem_doit); end
        b.c0_req = 1'b0;
        tick();
        n_cmp++; if (b.c0_ack !== 1'b0) begin n_bad++; $display("FAIL wr_ack_pulse: got %b want 0", b.c0_ack); end
        n_cmp++; if (doit_cnt - d0 !== 1) begin n_bad++; $display("FAIL wr_doit_count: got %0d want 1", doit_cnt - d0); end
        n_cmp++; if ({b.c0_rdata, b.c1_rdata} !== 16'h0000) begin n_bad++; $display("FAIL wr_rdata_kept: got %h want 0000", {b.c0_rdata, b.c1_rdata}); end
    endtask

    task automatic test_read;
        int lat, port;
        bit both;
        b.c1_we = 1'b0; b.c1_addr = 7'd5; b.c1_req = 1'b1;
        wait_any(10, lat, port, both);
        n_cmp++; if (port !== 1) begin n_bad++; $display("FAIL rd_port: got %0d want 1", port); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_cmp++; if (b.c1_rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_c1_rdata: got %h want a5", b.c1_rdata); end
        n_cmp++; if (b.c0_rdata !== 8'h00) begin n_bad++; $display("FAIL rd_c0_kept: got %h want 00", b.c0_rdata); end
        n_cmp++; if ({b.grant, b.mem_wselect, b.mem_addr} !== {1'b1, 1'b0, 7'd5}) begin n_bad++; $display("FAIL rd_grant_bus: got %h want %h", {b.grant, b.mem_wselect, b.mem_addr}, {1'b1, 1'b0, 7'd5}); end
        b.c1_req = 1'b0;
        tick();
    endtask

    task automatic test_contention;
        int lat, port;
        bit both;
        int exp_port [4];
`ifdef MEM_ARB_RR_EN
        exp_port = '{0, 1, 0, 1};
`else
        exp_port = '{0, 0, 0, 0};
`endif
        b.c0_we = 1'b0; b.c0_addr = 7'd1; b.c1_we = 1'b0; b.c1_addr = 7'd2;
        b.c0_req = 1'b1; b.c1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_any(10, lat, port, both);
            n_cmp++; if (port !== exp_port[k] || both) begin n_bad++; $display("FAIL arb_order_%0d: got port %0d both %b want port %0d", k, port, both, exp_port[k]); end
            n_cmp++; if (lat !== (k == 0 ? 3 : 4)) begin n_bad++; $display("FAIL arb_latency_%0d: got %0d want %0d", k, lat, k == 0 ? 3 : 4); end
            n_cmp++; if ((port == 1 ? b.c1_rdata : b.c0_rdata) !== (port == 1 ? 8'h42 : 8'h41)) begin n_bad++; $display("FAIL arb_rdata_%0d: got %h want %h", k, port == 1 ? b.c1_rdata : b.c0_rdata, port == 1 ? 8'h42 : 8'h41); end
        end
        b.c0_req = 1'b0;
        wait_any(10, lat, port, both);
        n_cmp++; if (port !== 1 || lat !== 4) begin n_bad++; $display("FAIL arb_lone_c1: got port %0d lat %0d want port 1 lat 4", port, lat); end
        n_cmp++; if (b.c1_rdata !== 8'h42) begin n_bad++; $display("FAIL arb_lone_rdata: got %h want 42", b.c1_rdata); end
        b.c1_req = 1'b0;
        tick();
    endtask

    task automatic test_busy;
        int d0;
        d0 = doit_cnt;
        b.c0_we = 1'b1; b.c0_addr = 7'd7; b.c0_wdata = 8'h5A; b.c0_req = 1'b1; b.mem_busy = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_cmp++; if (b.mem_doit !== 1'b0) begin n_bad++; $display("FAIL busy_hold_%0d: got doit %b want 0", c, b.mem_doit); end
        end
        tick();
        b.mem_busy = 1'b0;
        #1;
        n_cmp++; if (b.mem_doit !== 1'b1) begin n_bad++; $display("FAIL busy_release_doit: got %b want 1", b.mem_doit); end
        n_cmp++; if ({b.mem_addr, b.mem_wdata} !== {7'd7, 8'h5A}) begin n_bad++; $display("FAIL busy_bus: got %h want %h", {b.mem_addr, b.mem_wdata}, {7'd7, 8'h5A}); end
        tick();
        n_cmp++; if (b.c0_ack !== 1'b1) begin n_bad++; $display("FAIL busy_ack: got %b want 1", b.c0_ack); end
        n_cmp++; if (doit_cnt - d0 !== 1) begin n_bad++; $display("FAIL busy_doit_count: got %0d want 1", doit_cnt - d0); end
        b.c0_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        int lat, port;
        bit both;
        mute = 1'b1;
        b.c1_we = 1'b0; b.c1_addr = 7'd3; b.c1_req = 1'b1;
        wait_any(40, lat, port, both);
        n_cmp++; if (port !== 1 || lat !== 17) begin n_bad++; $display("FAIL to_ack: got port %0d lat %0d want port 1 lat 17", port, lat); end
        n_cmp++; if (b.err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", b.err); end
        n_cmp++; if (b.c1_rdata !== 8'hFF) begin n_bad++; $display("FAIL to_rdata: got %h want ff", b.c1_rdata); end
        n_cmp++; if (b.c0_rdata !== 8'h41) begin n_bad++; $display("FAIL to_c0_kept: got %h want 41", b.c0_rdata); end
        mute = 1'b0;
        b.c1_req = 1'b0;
        tick();
        b.c0_we = 1'b0; b.c0_addr = 7'd2; b.c0_req = 1'b1;
        wait_any(10, lat, port, both);
        n_cmp++; if (port !== 0 || lat !== 3) begin n_bad++; $display("FAIL to_after_ack: got port %0d lat %0d want port 0 lat 3", port, lat); end
        n_cmp++; if ({b.c0_rdata, b.err} !== {8'h42, 1'b1}) begin n_bad++; $display("FAIL to_err_sticky: got %h want %h", {b.c0_rdata, b.err}, {8'h42, 1'b1}); end
        b.c0_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        int lat, port, acks, d0;
        bit both;
        mute = 1'b1;
        b.c0_we = 1'b0; b.c0_addr = 7'd1; b.c0_req = 1'b1;
        repeat (3) tick();
        d0 = doit_cnt;
        b.c0_req = 1'b0;
        mute = 1'b0;
        test_reset();
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b.c0_ack || b.c1_ack) acks++;
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL rm_no_ack: got %0d acks want 0", acks); end
        n_cmp++; if (doit_cnt !== d0) begin n_bad++; $display("FAIL rm_no_doit: got %0d doits want %0d", doit_cnt, d0); end
        b.c1_we = 1'b1; b.c1_addr = 7'd9; b.c1_wdata = 8'h99; b.c1_req = 1'b1;
        wait_any(10, lat, port, both);
        n_cmp++; if (port !== 1 || lat !== 2) begin n_bad++; $display("FAIL rm_write: got port %0d lat %0d want port 1 lat 2", port, lat); end
        b.c1_req = 1'b0;
        tick();
        b.c1_we = 1'b0; b.c1_req = 1'b1;
        wait_any(10, lat, port, both);
        n_cmp++; if (port !== 1 || lat !== 3) begin n_bad++; $display("FAIL rm_read: got port %0d lat %0d want port 1 lat 3", port, lat); end
        n_cmp++; if (b.c1_rdata !== 8'h99) begin n_bad++; $display("FAIL rm_rdata: got %h want 99", b.c1_rdata); end
        b.c1_req = 1'b0;
        tick();
    endtask

    initial begin
        b.c0_req = 1'b0; b.c0_we = 1'b0; b.c0_addr = '0; b.c0_wdata = 8'h00;
        b.c1_req = 1'b0; b.c1_we = 1'b0; b.c1_addr = '0; b.c1_wdata = 8'h00;
        b.mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_busy();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arb2.md
Name: mem_arb2

Overview:
- Two-port arbiter and sequencer for the single-port byte data memory (doit/wselect/busy/rvalid protocol).
- Shares the memory between requester 0 (BF core tape access) and requester 1 (loader/debug port).
- Serialises accesses, drives one memory command at a time, and returns read data with a per-port ack pulse.
- Sits between the core/loader and the memory model or BRAM wrapper.

Parameters:
- logsize, 7, memory address width in bits (depth 2**logsize bytes).
- TIMEOUT, 15, max cycles spent in WAIT without mem_rvalid before flagging error (4-bit counter min; width = clog2(TIMEOUT+1)).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- c0_req  in  1  port 0 request, level, held until c0_ack
- c0_we  in  1  port 0 write(1)/read(0)
- c0_addr  in  logsize  port 0 byte address
- c0_wdata  in  8  port 0 write data
- c0_ack  out  1  port 0 one-cycle completion pulse
- c0_rdata  out  8  port 0 read data, valid in ack cycle, held until next port-0 read ack
- c1_req, c1_we, c1_addr, c1_wdata, c1_ack, c1_rdata: same as port 0, for port 1
- mem_addr  out  logsize  memory address
- mem_wdata  out  8  memory write data
- mem_wselect  out  1  memory write select
- mem_doit  out  1  memory command strobe, exactly one cycle per access
- mem_busy  in  1  memory busy; no mem_doit while high
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  8  memory read data
- grant  out  1  port owning the current or last transaction
- err  out  1  sticky read-timeout flag

Behaviour:
- Reset (rst low, async): state IDLE; all acks 0; mem_doit 0; mem_* buses 0; c0_rdata/c1_rdata 8'h00; grant 0; err 0; priority pointer favours port 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner (see priority) and latch its we/addr/wdata into the mem_* registers.
  - Set grant to the winner and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_doit=1 only when mem_busy=0; otherwise hold ISSUE with mem_doit=0.
  - On issue of a write, go to RESP.
  - On issue of a read, clear the timeout counter and go to WAIT.
- WAIT:
  - On mem_rvalid=1, capture mem_rdata into the granted port's rdata register and go to RESP.
  - Else increment the counter.
  - When the counter reaches TIMEOUT: set err=1, load 8'hFF into the granted rdata, and go to RESP.
- RESP:
  - Pulse the granted port's ack for exactly one cycle.
  - Update the priority pointer, then go to IDLE.
- Latency from req sampled in IDLE (cycle 0), with mem_busy low:
  - Write: mem_doit in cycle 1, ack in cycle 2.
  - Read: mem_doit in cycle 1; with the one-cycle memory, mem_rvalid in cycle 2 and ack in cycle 3.
- Requester rule: drop or change req in the cycle after ack.
  - IDLE follows RESP, so a req still high one cycle after ack is treated as a new request (back-to-back allowed).
- Arbitration is evaluated only in IDLE. A req arriving mid-transaction waits.
- Requests withdrawn before grant are ignored.
- Write does not alter either rdata register.
- mem_* address/data/wselect stay stable from IDLE exit until the next grant.
- Never more than one ack high at once; ack never goes to the ungranted port.
- mem_rvalid outside WAIT is ignored.
- err clears only on reset.
- Reset mid-transaction aborts immediately: no ack and no pending mem_doit.

Optional Feature:
- Macro: MEM_ARB_RR_EN
- Defined: round-robin.
  - When both reqs are high in IDLE, the port not served last wins.
  - Pointer updates in RESP; a single requester is always served.
- Undefined: fixed priority; port 0 always wins ties; the pointer logic is absent.

Test Plan:
- Port 0 write addr 5 data 8'hA5, idle port 1 -> mem_doit one cycle with mem_addr=5, mem_wselect=1, mem_wdata=A5; c0_ack at cycle 2; c1_ack stays 0.
- Port 1 read addr 5 after that write -> c1_ack at cycle 3, c1_rdata=8'hA5; c0_rdata unchanged.
- Both ports hold req (reads at addr 1 and 2) for 4 transactions:
  - RR build: order 0,1,0,1.
  - Fixed-priority build: port 0 served every time; port 1 served only after c0_req drops.
- mem_busy forced high 3 cycles while in ISSUE -> mem_doit withheld, then asserted in the first cycle busy is low; ack delayed by 3 cycles.
- Read with mem_rvalid never asserted, TIMEOUT=15 -> after 15 WAIT cycles err=1, ack with rdata=8'hFF; err stays 1 through later successful accesses.
- rst pulled low during WAIT -> all outputs reset value immediately; no ack after release; next request completes normally.
